// File: rtl/mac_sequencer.sv
// Sequences the operand buffer slots 1..N_IN, accumulates x*w in Q8.8 and hands
// one saturated result downstream on valid/ack. Define MAC_SEQUENCER_RELU_EN to clamp negative results to zero.
module mac_sequencer #(
  parameter int N_IN  = 3,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [15:0] x,
  input  logic [15:0] w,
  output logic [1:0]  sel,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ack,
  output logic        busy,
  output logic        overrun
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [1:0] LAST_IDX = 2'(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

`ifdef MAC_SEQUENCER_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                idx_p0;
  logic signed [ACC_W-1:0]   acc_p0;
  logic signed [PROD_W-1:0]  prod_p0;
  logic signed [ACC_W-1:0]   sum_p0;
  logic [DATA_W-1:0]         out_data_p1;
  logic                      pending_q, pending_d;
  logic                      overrun_q, overrun_d;

  // Drop the 8 fractional bits (floor), clamp to Q8.8, then optionally ReLU.
  function automatic logic [DATA_W-1:0] fmt_result(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
    logic [DATA_W-1:0]       r;
    sh = a >>> 8;
    if (sh > SAT_MAX)      r = 16'h7FFF;
    else if (sh < SAT_MIN) r = 16'h8000;
    else                   r = sh[DATA_W-1:0];
    if (RELU_EN && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  assign prod_p0 = $signed(x) * $signed(w);
  assign sum_p0  = acc_p0 + {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // A ready seen while busy is queued once; a second one is lost and flagged.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (ready || pending_q) begin
          state_d   = MAC;
          pending_d = ready && pending_q;
        end
      end
      MAC: begin
        if (idx_p0 == LAST_IDX) state_d = OUT;
      end
      OUT: begin
        if (out_ack) state_d = pending_q ? MAC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && ready) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
    if (state_q == OUT && out_ack && pending_q) pending_d = 1'b0;
  end

  always_comb begin
    sel       = 2'd0;
    busy      = (state_q != IDLE);
    out_valid = (state_q == OUT);
    if (state_q == MAC) sel = idx_p0;
  end

  // Accumulate stage; the final edge of MAC also registers the formatted result.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p0      <= 2'd0;
      acc_p0      <= '0;
      out_data_p1 <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready || pending_q) begin
            idx_p0 <= 2'd1;
            acc_p0 <= '0;
          end
        end
        MAC: begin
          acc_p0 <= sum_p0;
          if (idx_p0 == LAST_IDX) out_data_p1 <= fmt_result(sum_p0);
          else                    idx_p0 <= idx_p0 + 2'd1;
        end
        OUT: begin
          if (out_ack && pending_q) begin
            idx_p0 <= 2'd1;
            acc_p0 <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_data_p1;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: buffer model on sel, expected results queued
// at each ready pulse and compared when out_valid is observed.
module tb_mac_sequencer;

  localparam int N_IN = 3;

  logic        clk;
  logic        reset;
  logic        ready;
  logic [15:0] x;
  logic [15:0] w;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ack;
  logic        busy;
  logic        overrun;

  logic signed [15:0] slot_x [3];
  logic signed [15:0] slot_w [3];
  logic [15:0]        exp_q [$];
  int                 vectors = 0;
  int                 miscompares = 0;
  logic [15:0]        held;

  mac_sequencer #(.N_IN(N_IN), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .ready(ready), .x(x), .w(w), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    x = '0;
    w = '0;
    if (sel != 2'd0) begin
      x = slot_x[sel - 2'd1];
      w = slot_w[sel - 2'd1];
    end
  end

  function automatic logic [15:0] model();
    longint s;
    logic [15:0] r;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += longint'(slot_x[i]) * longint'(slot_w[i]);
    s = s >>> 8;
    if (s > 32767)       r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else                 r = s[15:0];
`ifdef MAC_SEQUENCER_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slots(input logic [15:0] x0, w0, x1, w1, x2, w2);
    slot_x[0] = x0; slot_w[0] = w0;
    slot_x[1] = x1; slot_w[1] = w1;
    slot_x[2] = x2; slot_w[2] = w2;
  endtask

  task automatic check_result(input string tag);
    logic [15:0] e;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_data"}, 32'(out_data), 32'(e));
    held = e;
  endtask

  task automatic ack_to_idle(input string tag);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ack_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag);
    exp_q.push_back(model());
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      check({tag, "_sel"}, 32'(sel), 32'(k));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
    check_result(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ready = 1'b0; out_ack = 1'b0;
    set_slots(16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'hFF00, 16'h0100);
    tick(); tick();
    reset = 1'b0;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // ack outside OUT must have no effect
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);

    run_op("sop");
    check("sop_const", 32'(out_data), 32'h0140);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(held));
    end
    ack_to_idle("sop");

    set_slots(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_op("sat_pos");
    check("sat_pos_const", 32'(out_data), 32'h7FFF);
    ack_to_idle("sat_pos");

    set_slots(16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF);
    run_op("sat_neg");
    ack_to_idle("sat_neg");

    set_slots(16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100);
    run_op("relu");
`ifdef MAC_SEQUENCER_RELU_EN
    check("relu_const", 32'(out_data), 32'h0000);
`else
    check("relu_const", 32'(out_data), 32'hFD00);
`endif
    ack_to_idle("relu");

    // Pending + overrun: two ready pulses during one MAC
    set_slots(16'h0100, 16'h0200, 16'h0080, 16'h0080, 16'hFF00, 16'h0100);
    exp_q.push_back(model());
    exp_q.push_back(model());
    ready = 1'b1;
    tick();
    check("pend_sel1", 32'(sel), 32'd1);
    tick();
    check("pend_sel2", 32'(sel), 32'd2);
    check("pend_no_ovr", 32'(overrun), 32'd0);
    tick();
    ready = 1'b0;
    check("pend_sel3", 32'(sel), 32'd3);
    check("ovr_set", 32'(overrun), 32'd1);
    tick();
    check_result("pend_first");
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("b2b_sel1", 32'(sel), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid", 32'(out_valid), 32'd0);
    tick();
    check("b2b_sel2", 32'(sel), 32'd2);
    tick();
    check("b2b_sel3", 32'(sel), 32'd3);
    tick();
    check_result("pend_second");
    check("pend_second_const", 32'(out_data), 32'h0140);
    ack_to_idle("pend_second");
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-MAC at idx=2
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("mid_sel2", 32'(sel), 32'd2);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    tick();
    run_op("after_rst");
    check("after_rst_const", 32'(out_data), 32'h0140);
    ack_to_idle("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
